// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared sizes, FSM states and frame packing for the dct16 sequencer
package dct_pkg;

    localparam int N           = 16;
    localparam int W           = 16;
    localparam int DCT_LATENCY = 2;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        COMPUTE = 2'd1,
        HANDOFF = 2'd2
    } state_e;

    typedef logic [N-1:0][W-1:0] frame_t;

    // Entry 0 lands in the least significant W bits, matching xin0/X0 of dct16.
    function automatic logic [N*W-1:0] pack_frame(input frame_t f);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*W +: W] = f[i];
        end
        return r;
    endfunction

    function automatic frame_t unpack_frame(input logic [N*W-1:0] v);
        frame_t f;
        for (int i = 0; i < N; i++) begin
            f[i] = v[i*W +: W];
        end
        return f;
    endfunction

endpackage

// File: rtl/dct16_out_serializer.sv
// rtl/dct16_out_serializer.sv - coefficient buffer drained one beat at a time on the m_* stream
module dct16_out_serializer
    import dct_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  frame_t       load_data,
    input  logic         m_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic [3:0]   m_index,
    output logic         m_last,
    output logic         out_full,
    output logic         done_next
);

    frame_t     out_buf_q, out_buf_d;
    logic [3:0] rd_idx_q, rd_idx_d;
    logic       out_full_q, out_full_d;

    always_comb begin
        out_buf_d  = out_buf_q;
        rd_idx_d   = rd_idx_q;
        out_full_d = out_full_q;
        done_next  = out_full_q && m_ready && (rd_idx_q == 4'd15);
        // A load coinciding with the final beat takes priority so there is no bubble.
        if (load) begin
            out_buf_d  = load_data;
            rd_idx_d   = 4'd0;
            out_full_d = 1'b1;
        end else if (out_full_q && m_ready) begin
            rd_idx_d = rd_idx_q + 4'd1;
            if (rd_idx_q == 4'd15) begin
                out_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_buf_q  <= '0;
            rd_idx_q   <= 4'd0;
            out_full_q <= 1'b0;
        end else begin
            out_buf_q  <= out_buf_d;
            rd_idx_q   <= rd_idx_d;
            out_full_q <= out_full_d;
        end
    end

    assign m_valid  = out_full_q;
    assign m_data   = out_buf_q[rd_idx_q];
    assign m_index  = rd_idx_q;
    assign m_last   = (rd_idx_q == 4'd15);
    assign out_full = out_full_q;

endmodule

// File: rtl/dct16_stream_ctrl.sv
// rtl/dct16_stream_ctrl.sv - collects a sample frame, holds it for dct16, hands results to the serializer
module dct16_stream_ctrl
    import dct_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    input  logic           s_last,
    output logic [N*W-1:0] dct_x,
    input  logic [N*W-1:0] dct_X,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    output logic [3:0]     m_index,
    output logic           m_last,
    output logic           busy,
    output logic [15:0]    frames_done
);

    state_e      state_q, state_d;
    frame_t      in_buf_q, in_buf_d;
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] frames_done_q, frames_done_d;
    logic        load;
    logic        out_full;
    logic        done_next;

    always_comb begin
        state_d       = state_q;
        in_buf_d      = in_buf_q;
        wr_idx_d      = wr_idx_q;
        wait_cnt_d    = wait_cnt_q;
        frames_done_d = frames_done_q;
        s_ready       = 1'b0;
        load          = 1'b0;
        case (state_q)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    in_buf_d[wr_idx_q] = s_data;
                    if (wr_idx_q == 4'd15 || s_last) begin
                        // Short frames are zero-padded so stale samples never reach dct16.
                        for (int i = 0; i < N; i++) begin
                            if (i > int'(wr_idx_q)) begin
                                in_buf_d[i] = '0;
                            end
                        end
                        wr_idx_d   = 4'd0;
                        wait_cnt_d = 2'd0;
                        state_d    = COMPUTE;
                    end else begin
                        wr_idx_d = wr_idx_q + 4'd1;
                    end
                end
            end
            COMPUTE: begin
                wait_cnt_d = wait_cnt_q + 2'd1;
                if (wait_cnt_q == 2'(DCT_LATENCY - 1)) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                if (!out_full || done_next) begin
                    load          = 1'b1;
                    frames_done_d = frames_done_q + 16'd1;
                    state_d       = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            in_buf_q      <= '0;
            wr_idx_q      <= 4'd0;
            wait_cnt_q    <= 2'd0;
            frames_done_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            in_buf_q      <= in_buf_d;
            wr_idx_q      <= wr_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            frames_done_q <= frames_done_d;
        end
    end

    assign dct_x       = pack_frame(in_buf_q);
    assign busy        = (state_q != FILL) || (wr_idx_q != 4'd0) || out_full;
    assign frames_done = frames_done_q;

    dct16_out_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (unpack_frame(dct_X)),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_last    (m_last),
        .out_full  (out_full),
        .done_next (done_next)
    );

endmodule
